debug_host_initiator: RTL and testbench
=======================================

# debug_host_initiator

Host-side initiator for the UART debug command protocol: accepts one command at a time on a valid/ready request port and serializes it into a byte stream for a UART transmitter. It then collects the target's reply from the UART receiver and returns a single-cycle response with status. It sits between a host agent (bench driver, boot loader, JTAG bridge) and a `uart` instance, facing the target-side debug controller across the serial link.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000000, cycles without a received reply byte before a command is aborted; counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `CLK`  in  1  clock; one clock domain.
- `RST_N`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_cmd`  in  3  0=PING, 1=WRITE, 2=READ, 3=HALT, 4=GO; 5-7 illegal.
- `req_addr`  in  32  target address (WRITE/READ).
- `req_wdata`  in  32  write data (WRITE).
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  32  READ data, or the offending byte in [7:0] on bad ack.
- `resp_err`  out  1  command failed.
- `resp_timeout`  out  1  failure was a timeout.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_byte`  out  8  byte to UART transmitter.
- `tx_start`  out  1  transmit strobe.
- `tx_busy`  in  1  UART transmitter busy.
- `rx_byte`  in  8  byte from UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid in that cycle.

## Operation
- Opcodes: PING 0x50, WRITE 0x57, READ 0x52, HALT 0x48, GO 0x47. The ack byte is 0x41.
- Frame lengths: PING/HALT/GO send 1 byte; READ sends 5 (opcode, addr MSB first); WRITE sends 9 (opcode, addr MSB first, data MSB first).
- On accept (`req_valid && req_ready`), latch cmd/addr/wdata and clear byte index to 0.
- States: IDLE, SEND, GAP, WAIT_ACK, RECV_DATA, RESP.
  - IDLE -> SEND on accept of a legal cmd; IDLE -> RESP on an illegal cmd, with err=1 and timeout=0.
  - SEND: `tx_start = (state==SEND) && !tx_busy`. `tx_byte` is the framed byte selected by the index. A strobe advances to GAP.
  - GAP: exactly one cycle. The index increments. -> SEND if bytes remain; otherwise -> RECV_DATA for READ, WAIT_ACK for all other cmds.
  - WAIT_ACK: rx byte 0x41 -> RESP with err=0. Any other byte -> RESP with err=1, rdata={24'b0,byte}.
  - RECV_DATA: shift rx bytes in MSB first (`rdata <= {rdata[23:0], rx_byte}`). After the 4th byte -> RESP with err=0.
  - RESP: `resp_valid`=1 for one cycle, then IDLE.
- Timeout counter:
  - Clears on entry to WAIT_ACK/RECV_DATA and on every rx byte.
  - Reaching `TIMEOUT_CYCLES` -> RESP with err=1 and timeout=1. `rdata` holds any partial bytes.
- `rx_valid` outside WAIT_ACK/RECV_DATA is discarded.
- The READ rdata shift register clears on accept.

## Timing
- Reset values: `req_ready`=0 during reset and 1 the first cycle after. `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `resp_timeout`=0, `busy`=0, `tx_start`=0, `tx_byte`=0x00.
- `resp_*` data/status are registered and hold until the next response.
- PING with `tx_busy` low throughout:
  - accept at cycle 0;
  - `tx_start` at cycle 1;
  - GAP at cycle 2;
  - WAIT_ACK from cycle 3.
  - An ack at cycle k gives `resp_valid` at k+1, and `req_ready` is high at k+2.
- Each byte costs at least 2 cycles (SEND+GAP). GAP gives the UART one cycle to raise `tx_busy`.
- `tx_byte` is stable from its strobe cycle until the next strobe.
- A strobe is never issued while `tx_busy`=1.
- If `rx_valid` and timeout expiry land in the same cycle, the byte wins and the counter clears.
- Reset mid-command abandons the frame and returns to reset values. No response is issued.

## Test plan
- PING, target answers 0x41 after 50 cycles -> tx sequence {0x50}; one `resp_valid` with err=0, timeout=0.
- WRITE addr=0x00001000 data=0xDEADBEEF, `tx_busy` high 20 cycles per byte -> tx sequence 57 00 00 10 00 DE AD BE EF with no strobe while busy; ack gives err=0.
- READ addr=0x00000004, target returns 12 34 56 78 -> tx sequence 52 00 00 00 04; `resp_rdata`=0x12345678, err=0.
- HALT answered with 0x4E -> err=1, timeout=0, `resp_rdata`=0x0000004E. Then an illegal cmd 6 -> `resp_valid` 1 cycle after accept, err=1, no `tx_start`.
- `TIMEOUT_CYCLES`=100, READ answered with only 2 bytes -> `resp_valid` 100 cycles after the 2nd byte, err=1, timeout=1, rdata[15:0] equal to those bytes.
- Drop `RST_N` for 1 cycle after the 3rd WRITE byte -> all outputs at reset values, no `resp_valid`. A following PING completes normally.

Source files
------------

// File: rtl/debug_host_initiator.sv
// debug_host_initiator: frames one debug command onto a UART byte stream and collects the target reply.
// Latency: accept -> first tx_start 1 cycle (tx idle); final reply byte -> resp_valid 1 cycle; illegal cmd -> resp_valid 1 cycle.
// Backpressure: one command in flight (req_ready only in IDLE); tx_start withheld while tx_busy; resp has no backpressure.
module debug_host_initiator #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_timeout,
  output logic        busy,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_HALT  = 3'd3;
  localparam logic [2:0] CMD_GO    = 3'd4;
  localparam logic [7:0] ACK_BYTE  = 8'h41;

  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_ACK, RECV_DATA, RESP} state_t;

  state_t         state;
  logic           ready_q;
  logic [2:0]     cmd_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     idx;
  logic [1:0]     rx_cnt;
  logic [31:0]    shift;
  logic [CW-1:0]  cnt;
  logic [7:0]     tx_hold;
  logic [7:0]     opcode;
  logic [3:0]     frame_len;
  logic [7:0]     frame_byte;

  // Opcode and total frame length of the latched command
  always_comb begin
    opcode    = 8'h50;
    frame_len = 4'd1;
    case (cmd_q)
      CMD_WRITE: begin opcode = 8'h57; frame_len = 4'd9; end
      CMD_READ:  begin opcode = 8'h52; frame_len = 4'd5; end
      CMD_HALT:  opcode = 8'h48;
      CMD_GO:    opcode = 8'h47;
      default:   ;
    endcase
  end

  // Byte of the frame at the current index: opcode, then address and data MSB first
  always_comb begin
    frame_byte = opcode;
    case (idx)
      4'd1:    frame_byte = addr_q[31:24];
      4'd2:    frame_byte = addr_q[23:16];
      4'd3:    frame_byte = addr_q[15:8];
      4'd4:    frame_byte = addr_q[7:0];
      4'd5:    frame_byte = wdata_q[31:24];
      4'd6:    frame_byte = wdata_q[23:16];
      4'd7:    frame_byte = wdata_q[15:8];
      4'd8:    frame_byte = wdata_q[7:0];
      default: ;
    endcase
  end

  // The strobe presents the new byte; outside it the last strobed byte is held so tx_byte
  // only changes on a strobe.
  assign tx_start  = (state == SEND) && !tx_busy;
  assign tx_byte   = tx_start ? frame_byte : tx_hold;
  assign busy      = (state != IDLE);
  assign req_ready = ready_q;

  // Command FSM with registered handshake and response outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      ready_q      <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
      cmd_q        <= 3'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      idx          <= 4'd0;
      rx_cnt       <= 2'd0;
      shift        <= 32'h0;
      cnt          <= '0;
      tx_hold      <= 8'h00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            cmd_q   <= req_cmd;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx     <= 4'd0;
            shift   <= 32'h0;
            if (req_cmd <= CMD_GO) begin
              state <= SEND;
            end else begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_err     <= 1'b1;
              resp_timeout <= 1'b0;
              resp_rdata   <= 32'h0;
            end
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_hold <= frame_byte;
            state   <= GAP;
          end
        end
        GAP: begin
          idx <= idx + 4'd1;
          if (idx + 4'd1 < frame_len) begin
            state <= SEND;
          end else begin
            cnt    <= '0;
            rx_cnt <= 2'd0;
            state  <= (cmd_q == CMD_READ) ? RECV_DATA : WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (rx_valid) begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_timeout <= 1'b0;
            if (rx_byte == ACK_BYTE) begin
              resp_err   <= 1'b0;
              resp_rdata <= shift;
            end else begin
              resp_err   <= 1'b1;
              resp_rdata <= {24'h0, rx_byte};
            end
          end else if (cnt >= TO_LAST) begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            resp_rdata   <= shift;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RECV_DATA: begin
          if (rx_valid) begin
            shift  <= {shift[23:0], rx_byte};
            rx_cnt <= rx_cnt + 2'd1;
            // The byte's own cycle counts as the first elapsed cycle, so the abort
            // lands exactly TIMEOUT_CYCLES cycles after the last byte.
            cnt    <= CW'(1);
            if (rx_cnt == 2'd3) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_err     <= 1'b0;
              resp_timeout <= 1'b0;
              resp_rdata   <= {shift[23:0], rx_byte};
            end
          end else if (cnt >= TO_LAST) begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            resp_rdata   <= shift;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host_initiator.sv
// tb_debug_host_initiator: directed and random debug commands against a frame/reply reference model.
// Latency: bench steps one cycle per tick, sampling 2 time units after the rising edge.
// Backpressure: bench emulates UART tx_busy for a programmable number of cycles per strobed byte.
module tb_debug_host_initiator;

  localparam int TO = 100;
  typedef logic [7:0] bq_t[$];

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic        busy;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_byte;
  logic        rx_valid;

  debug_host_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_timeout(resp_timeout), .busy(busy),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_byte(rx_byte), .rx_valid(rx_valid)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_len = 0;
  int busy_left = 0;
  int rx_due = 0;
  int rx_gap = 1;
  int last_rx_cyc = -1;
  int resp_cnt = 0;
  int resp_cyc = -1;
  int first_strobe_cyc = -1;
  bq_t txq;
  bq_t rx_q;
  bq_t rep;
  logic [31:0] cap_rdata;
  logic        cap_err;
  logic        cap_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected byte stream for a command, built from opcode table and MSB-first fields
  function automatic bq_t build_frame(input int cmd, input logic [31:0] a, input logic [31:0] w);
    bq_t f;
    case (cmd)
      0: f.push_back(8'h50);
      1: f.push_back(8'h57);
      2: f.push_back(8'h52);
      3: f.push_back(8'h48);
      4: f.push_back(8'h47);
      default: ;
    endcase
    if (cmd == 1 || cmd == 2)
      for (int i = 3; i >= 0; i--) f.push_back(8'((a >> (8 * i)) & 32'hFF));
    if (cmd == 1)
      for (int i = 3; i >= 0; i--) f.push_back(8'((w >> (8 * i)) & 32'hFF));
    return f;
  endfunction

  task automatic observe();
    if (tx_busy) check("no_strobe_while_busy", 32'(tx_start), 32'd0);
    if (tx_start) begin
      if (txq.size() == 0) first_strobe_cyc = cyc;
      txq.push_back(tx_byte);
      busy_left = busy_len + 1;
    end
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc  = cyc;
      cap_rdata = resp_rdata;
      cap_err   = resp_err;
      cap_to    = resp_timeout;
    end
  endtask

  // One clock cycle: UART and target models drive inputs, then outputs are sampled
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (busy_left > 0) busy_left--;
    tx_busy  = (busy_left > 0);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    if (rx_q.size() > 0 && cyc >= rx_due) begin
      rx_valid    = 1'b1;
      rx_byte     = rx_q.pop_front();
      rx_due      = cyc + rx_gap;
      last_rx_cyc = cyc;
    end
    #1;
    observe();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_resp_timeout"}, 32'(resp_timeout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_byte"}, 32'(tx_byte), 32'h0);
  endtask

  task automatic run_cmd(input string tag, input int cmd, input logic [31:0] a, input logic [31:0] w,
                         input int blen, input bq_t reply, input int delay, input int gap);
    bq_t         exp_tx;
    int          t;
    int          acc_cyc;
    int          n;
    bit          legal;
    bit          exp_err;
    bit          exp_to;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    legal  = (cmd < 5);
    exp_tx = build_frame(cmd, a, w);
    busy_len = blen;
    busy_left = 0;
    txq.delete();
    rx_q.delete();
    resp_cnt = 0;
    last_rx_cyc = -1;
    first_strobe_cyc = -1;

    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin tick(); t++; end
    check({tag, "_ready_before_accept"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cmd   = 3'(cmd);
    req_addr  = a;
    req_wdata = w;
    acc_cyc   = cyc;
    tick();
    req_valid = 1'b0;

    t = 0;
    while (txq.size() < exp_tx.size() && resp_cnt == 0 && t < 2000) begin tick(); t++; end
    rx_q   = reply;
    rx_gap = gap;
    rx_due = cyc + delay;
    t = 0;
    while (resp_cnt == 0 && t < 1000) begin tick(); t++; end
    check({tag, "_resp_seen"}, 32'(resp_cnt), 32'd1);

    check({tag, "_tx_count"}, 32'(txq.size()), 32'(exp_tx.size()));
    n = (txq.size() < exp_tx.size()) ? txq.size() : exp_tx.size();
    for (int i = 0; i < n; i++) check({tag, "_tx_byte"}, 32'(txq[i]), 32'(exp_tx[i]));
    if (legal) check({tag, "_first_strobe_cycle"}, 32'(first_strobe_cyc), 32'(acc_cyc + 1));

    // Reference response from the command kind and the reply bytes the target sent
    exp_err = 1'b0; exp_to = 1'b0; chk_rdata = 1'b1; exp_rdata = 32'h0;
    if (!legal) begin
      exp_err = 1'b1; chk_rdata = 1'b0;
    end else if (cmd == 2) begin
      for (int i = 0; i < reply.size() && i < 4; i++) exp_rdata = (exp_rdata << 8) | 32'(reply[i]);
      if (reply.size() < 4) begin exp_err = 1'b1; exp_to = 1'b1; end
    end else if (reply.size() == 0) begin
      exp_err = 1'b1; exp_to = 1'b1;
    end else if (reply[0] == 8'h41) begin
      chk_rdata = 1'b0;
    end else begin
      exp_err = 1'b1; exp_rdata = 32'(reply[0]);
    end
    if (resp_cnt == 1) begin
      check({tag, "_resp_err"}, 32'(cap_err), 32'(exp_err));
      check({tag, "_resp_timeout"}, 32'(cap_to), 32'(exp_to));
      if (chk_rdata) check({tag, "_resp_rdata"}, cap_rdata, exp_rdata);
      if (!legal) check({tag, "_resp_cycle"}, 32'(resp_cyc), 32'(acc_cyc + 1));
      else if (!exp_to) check({tag, "_resp_cycle"}, 32'(resp_cyc), 32'(last_rx_cyc + 1));
      else if (reply.size() > 0) check({tag, "_timeout_cycle"}, 32'(resp_cyc), 32'(last_rx_cyc + TO));
      tick();
      check({tag, "_resp_one_cycle"}, 32'(resp_valid), 32'd0);
      check({tag, "_ready_after_resp"}, 32'(req_ready), 32'd1);
      check({tag, "_resp_held"}, 32'(resp_err), 32'(exp_err));
    end
  endtask

  task automatic reset_mid_write();
    int t;
    busy_len = 2; busy_left = 0; txq.delete(); rx_q.delete(); resp_cnt = 0;
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin tick(); t++; end
    req_valid = 1'b1; req_cmd = 3'd1; req_addr = 32'h0000_2000; req_wdata = 32'h1234_5678;
    tick();
    req_valid = 1'b0;
    t = 0;
    while (txq.size() < 3 && t < 500) begin tick(); t++; end
    check("rst_third_byte_sent", 32'(txq.size()), 32'd3);
    RST_N = 1'b0;
    tick();
    check_reset_vals("rst_mid");
    RST_N = 1'b1;
    tick();
    check("rst_mid_ready_after", 32'(req_ready), 32'd1);
    repeat (30) tick();
    check("rst_mid_no_resp", 32'(resp_cnt), 32'd0);
    check("rst_mid_no_more_tx", 32'(txq.size()), 32'd3);
  endtask

  initial begin
    int cmd;
    int kind;
    int nb;
    logic [31:0] a;
    logic [31:0] w;
    logic [7:0]  b;
    RST_N = 1'b0; req_valid = 1'b0; req_cmd = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    tx_busy = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    RST_N = 1'b1;
    tick();
    check("reset_ready_after", 32'(req_ready), 32'd1);

    rep.delete(); rep.push_back(8'h41);
    run_cmd("ping", 0, 32'h0, 32'h0, 0, rep, 50, 1);

    rep.delete(); rep.push_back(8'h41);
    run_cmd("write", 1, 32'h0000_1000, 32'hDEAD_BEEF, 20, rep, 5, 1);

    rep.delete(); rep.push_back(8'h12); rep.push_back(8'h34); rep.push_back(8'h56); rep.push_back(8'h78);
    run_cmd("read", 2, 32'h0000_0004, 32'h0, 0, rep, 4, 3);

    rep.delete(); rep.push_back(8'h4E);
    run_cmd("halt_nak", 3, 32'h0, 32'h0, 0, rep, 7, 1);

    rep.delete();
    run_cmd("illegal6", 6, 32'hFFFF_FFFF, 32'h0, 0, rep, 2, 1);

    rep.delete(); rep.push_back(8'hA5); rep.push_back(8'h3C);
    run_cmd("read_timeout", 2, 32'h0000_0010, 32'h0, 1, rep, 3, 5);

    reset_mid_write();
    rep.delete(); rep.push_back(8'h41);
    run_cmd("ping_after_rst", 0, 32'h0, 32'h0, 0, rep, 10, 1);

    for (int it = 0; it < 16; it++) begin
      cmd  = int'($urandom_range(0, 7));
      a    = $urandom;
      w    = $urandom;
      kind = int'($urandom_range(0, 2));
      rep.delete();
      if (cmd == 2) begin
        nb = (kind == 2) ? int'($urandom_range(0, 3)) : 4;
        for (int i = 0; i < nb; i++) rep.push_back(8'($urandom_range(0, 255)));
      end else if (cmd < 5 && kind == 0) begin
        rep.push_back(8'h41);
      end else if (cmd < 5 && kind == 1) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h41) b = 8'h42;
        rep.push_back(b);
      end
      run_cmd("random", cmd, a, w, int'($urandom_range(0, 4)), rep,
              int'($urandom_range(2, 30)), int'($urandom_range(1, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
